// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and sizing helpers for the serial subtractor.
// Revision: 1.0
`default_nettype none

package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 1;
  endfunction

  // One extra bit so the terminal count is representable without wrapping.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(num_digits(width, digit)) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_digit_sub.sv
// serial_subtractor_digit_sub: DIGIT-wide combinational borrow subtract cell.
// Revision: 1.0
`default_nettype none

module serial_subtractor_digit_sub #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] diff;

  // The extra top bit of the widened difference is exactly the borrow-out.
  assign diff = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  assign d    = diff[DIGIT-1:0];
  assign bout = diff[DIGIT];

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial lhs - rhs - bin with valid/ready operand and result handshakes.
// Revision: 1.0
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic             io_bin,
  input  logic [WIDTH-1:0] io_lhs,
  input  logic [WIDTH-1:0] io_rhs,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_bout
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int CNT_W      = cnt_width(WIDTH, DIGIT);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  state_t             state;
  state_t             state_next;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   lhs_sh;
  logic [WIDTH-1:0]   rhs_sh;
  logic [WIDTH-1:0]   res_sh;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   out_q;
  logic               bout_q;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT-1:0]   digit_d;
  logic               digit_b;
  logic               accept;
  logic               handoff;
  logic               last_digit;

  assign accept     = io_in_valid && in_ready_q;
  assign handoff    = out_valid_q && io_out_ready;
  assign last_digit = (cnt == CNT_W'(NUM_DIGITS - 1));

  serial_subtractor_digit_sub #(
    .DIGIT (DIGIT)
  ) u_digit_sub (
    .a    (lhs_sh[DIGIT-1:0]),
    .b    (rhs_sh[DIGIT-1:0]),
    .bin  (borrow),
    .d    (digit_d),
    .bout (digit_b)
  );

  // New digits enter at the MSB end so the LSB digit lands at bit 0 after the last step.
  if (DIGIT == WIDTH) begin : g_full_digit
    assign res_next = digit_d;
  end else begin : g_shift_digit
    assign res_next = {digit_d, res_sh[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = BUSY;
      BUSY:    if (last_digit) state_next = DONE;
      DONE:    if (handoff)    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they stay low during reset
  // and in_ready only rises on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      lhs_sh      <= '0;
      rhs_sh      <= '0;
      res_sh      <= '0;
      out_q       <= '0;
      bout_q      <= 1'b0;
      borrow      <= 1'b0;
      cnt         <= '0;
    end else begin
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            lhs_sh <= io_lhs;
            rhs_sh <= io_rhs;
            borrow <= io_bin;
            res_sh <= '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          borrow <= digit_b;
          res_sh <= res_next;
          lhs_sh <= lhs_sh >> DIGIT;
          rhs_sh <= rhs_sh >> DIGIT;
          cnt    <= cnt + CNT_W'(1);
          if (last_digit) begin
            out_q  <= res_next;
            bout_q <= digit_b;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_in_ready  = in_ready_q;
  assign io_out_valid = out_valid_q;
  assign io_out       = out_q;
  assign io_bout      = bout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the serial subtractor at 8b/4b-digit and 16b/1b-digit.
// Revision: 1.0
`default_nettype none

module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        a_in_valid = 1'b0, a_in_ready, a_bin = 1'b0, a_out_valid, a_out_ready = 1'b0, a_bout;
  logic [7:0]  a_lhs = '0, a_rhs = '0, a_out;
  logic        b_in_valid = 1'b0, b_in_ready, b_bin = 1'b0, b_out_valid, b_out_ready = 1'b0, b_bout;
  logic [15:0] b_lhs = '0, b_rhs = '0, b_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (a_in_valid),
    .io_in_ready  (a_in_ready),
    .io_bin       (a_bin),
    .io_lhs       (a_lhs),
    .io_rhs       (a_rhs),
    .io_out_valid (a_out_valid),
    .io_out_ready (a_out_ready),
    .io_out       (a_out),
    .io_bout      (a_bout)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (b_in_valid),
    .io_in_ready  (b_in_ready),
    .io_bin       (b_bin),
    .io_lhs       (b_lhs),
    .io_rhs       (b_rhs),
    .io_out_valid (b_out_valid),
    .io_out_ready (b_out_ready),
    .io_out       (b_out),
    .io_bout      (b_bout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance a (sel=0) or b (sel=1); hold = cycles of backpressure,
  // scramble = drive different operands while the block is busy.
  task automatic op(input bit sel, input logic [15:0] l, input logic [15:0] r, input logic bi,
                    input logic [15:0] exp_out, input logic exp_bout, input int exp_lat,
                    input int hold, input bit scramble, input string tag);
    int lat;
    logic [15:0] out_s;
    logic        bout_s;
    @(negedge clk);
    check({tag, " in_ready"}, sel ? b_in_ready : a_in_ready, 1);
    if (!sel) begin
      a_lhs = l[7:0]; a_rhs = r[7:0]; a_bin = bi; a_in_valid = 1'b1;
    end else begin
      b_lhs = l; b_rhs = r; b_bin = bi; b_in_valid = 1'b1;
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    if (scramble) begin
      a_lhs = 8'hFF; a_rhs = 8'h00; a_bin = 1'b1;
      b_lhs = 16'hFFFF; b_rhs = 16'h0000; b_bin = 1'b1;
    end
    lat = 0;
    while (!(sel ? b_out_valid : a_out_valid) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " out"}, sel ? b_out : {8'h00, a_out}, exp_out);
    check({tag, " bout"}, sel ? b_bout : a_bout, exp_bout);
    out_s  = sel ? b_out : {8'h00, a_out};
    bout_s = sel ? b_bout : a_bout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, sel ? b_out_valid : a_out_valid, 1);
      check({tag, " hold out"}, sel ? b_out : {8'h00, a_out}, out_s);
      check({tag, " hold bout"}, sel ? b_bout : a_bout, bout_s);
      check({tag, " hold in_ready"}, sel ? b_in_ready : a_in_ready, 0);
    end
    if (!sel) a_out_ready = 1'b1; else b_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    check({tag, " valid drop"}, sel ? b_out_valid : a_out_valid, 0);
    check({tag, " in_ready back"}, sel ? b_in_ready : a_in_ready, 1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst in_ready", a_in_ready, 0);
    check("rst out_valid", a_out_valid, 0);
    check("rst out", a_out, 0);
    check("rst bout", a_bout, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", a_in_ready, 1);

    // 8-bit, 4-bit digits
    op(0, 16'h35, 16'h12, 1'b0, 16'h23, 1'b0, 2, 0, 0, "a 35-12");
    op(0, 16'h00, 16'h01, 1'b0, 16'hFF, 1'b1, 2, 0, 0, "a 00-01");
    op(0, 16'h10, 16'h0F, 1'b1, 16'h00, 1'b0, 2, 0, 0, "a 10-0F-1");
    op(0, 16'h5A, 16'h5A, 1'b0, 16'h00, 1'b0, 2, 0, 0, "a eq");
    op(0, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1, 2, 0, 0, "a 0-0-1");
    op(0, 16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1, 2, 0, 0, "a FF-FF-1");
    op(0, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 2, 10, 0, "a backpressure");
    op(0, 16'hA0, 16'h05, 1'b0, 16'h9B, 1'b0, 2, 0, 1, "a operand change");

    // Abort during the first busy cycle
    @(negedge clk);
    a_lhs = 8'h77; a_rhs = 8'h11; a_bin = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort out_valid", a_out_valid, 0);
    check("abort out", a_out, 0);
    check("abort in_ready", a_in_ready, 0);
    check("abort bout", a_bout, 0);
    repeat (3) @(negedge clk);
    check("abort hold out_valid", a_out_valid, 0);
    check("abort hold in_ready", a_in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort release in_ready", a_in_ready, 1);
    op(0, 16'h01, 16'h01, 1'b0, 16'h00, 1'b0, 2, 0, 0, "a after abort");

    // 16-bit, 1-bit digits
    op(1, 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 16, 0, 0, "b 1234-0235");
    op(1, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 16, 0, 0, "b 0-FFFF-1");
    op(1, 16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 16, 0, 0, "b 8000-1-1");
    op(1, 16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 16, 0, 0, "b eq");
    op(1, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 16, 3, 1, "b 1-2 bp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle borrow-chain subtractor, the inverse datapath of the combinational carry adder: computes io_lhs - io_rhs - io_bin and returns the difference plus a borrow-out.
- Processes DIGIT bits per cycle, least significant digit first, so wide operands reuse one narrow subtract stage.
- Operands enter and results leave on independent valid/ready handshakes, so the block drops into streaming arithmetic pipelines.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits subtracted per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately when 0.
- io_in_valid  input  1  operand bundle valid.
- io_in_ready  output  1  block can accept operands.
- io_bin  input  1  borrow-in (subtracted at bit 0).
- io_lhs  input  WIDTH  minuend.
- io_rhs  input  WIDTH  subtrahend.
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  consumer accepts result.
- io_out  output  WIDTH  difference modulo 2^WIDTH.
- io_bout  output  1  borrow-out: 1 iff lhs < rhs + bin as unsigned values.

Behaviour:
- FSM has three states: IDLE, BUSY, DONE. While reset=0: state=IDLE, io_in_ready=0, io_out_valid=0, io_out=0, io_bout=0, digit counter=0, borrow register=0.
- The first rising clk after reset release must leave io_in_ready=1 (IDLE).
- IDLE:
  - io_in_ready=1, io_out_valid=0.
  - On io_in_valid&&io_in_ready, latch lhs, rhs and bin into shift registers, clear the result register and counter, and go to BUSY.
- BUSY:
  - io_in_ready=0.
  - Each cycle, compute {b,d} = {1'b0,lhs[DIGIT-1:0]} - {1'b0,rhs[DIGIT-1:0]} - borrow, in DIGIT+1-bit arithmetic.
  - borrow <= b. Shift d into the result MSB end. Shift lhs and rhs right by DIGIT. Counter increments.
  - After WIDTH/DIGIT cycles, go to DONE.
  - Total latency is WIDTH/DIGIT cycles from the accept edge to the edge that raises io_out_valid.
- DONE:
  - io_out_valid=1. io_out and io_bout are stable and registered.
  - They must hold unchanged while io_out_ready=0 (indefinite backpressure).
  - On io_out_valid&&io_out_ready, go to IDLE.
  - No same-cycle re-accept: io_in_ready rises the cycle after the handshake, so back-to-back throughput is one result per WIDTH/DIGIT+2 cycles.
- Input handshake: io_in_valid may be asserted in any state. Operands are sampled only on the accept edge; later changes to io_lhs, io_rhs and io_bin are ignored.
- io_out/io_bout in IDLE and BUSY hold the last completed result (0 after reset). They are don't-care to consumers when io_out_valid=0.
- Width rules:
  - Result is exact modulo 2^WIDTH. io_bout is the final borrow.
  - DIGIT=WIDTH degenerates to a 1-cycle BUSY.
  - Counter width is clog2(WIDTH/DIGIT)+1 to avoid wrap at the terminal count.
- Reset mid-operation: reset assertion in BUSY or DONE aborts immediately. The in-flight result is discarded, outputs return to reset values, and io_out_valid never pulses.
- Boundary cases:
  - lhs=rhs, bin=0: result 0, bout 0.
  - lhs=0, rhs=0, bin=1: result all-ones, bout 1.
  - lhs=all-ones, rhs=all-ones, bin=1: result all-ones, bout 1.

Decomposition:
- Shared arithmetic package holds:
  - The state encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - A function or constant for NUM_DIGITS=WIDTH/DIGIT and the counter width.
- One sub-module is natural: digit_sub.
  - Purely combinational, DIGIT-wide: inputs a, b, bin; outputs d, bout.
  - Instantiated once; it is the inverse of the existing combinational adder cell.
- An elaboration-time check rejects WIDTH%DIGIT != 0.

Test Plan:
- WIDTH=8, DIGIT=4; lhs=0x35, rhs=0x12, bin=0 -> io_out_valid rises 2 cycles after accept, io_out=0x23, io_bout=0.
- lhs=0x00, rhs=0x01, bin=0 -> io_out=0xFF, io_bout=1. Separately, lhs=0x10, rhs=0x0F, bin=1 -> io_out=0x00, io_bout=0 (borrow propagates across the digit boundary).
- Backpressure: hold io_out_ready=0 for 10 cycles after valid -> io_out and io_bout are constant and io_in_ready=0 throughout. Then assert io_out_ready -> io_out_valid drops next cycle and io_in_ready=1.
- Operand change after accept: accept lhs=0xA0, rhs=0x05, then drive io_lhs=0xFF during BUSY -> io_out=0x9B, io_bout=0.
- Reset mid-op: pull reset low during the first BUSY cycle -> io_out_valid=0, io_out=0, io_in_ready=0 while low. On release, the block returns to IDLE and the next op lhs=0x01, rhs=0x01 yields 0x00, bout 0.
- WIDTH=16, DIGIT=1, random 1000 ops vs. reference model (lhs-rhs-bin mod 2^16, borrow) -> all match; latency exactly 16 cycles each.
